// File: rtl/acc_dummy_gen_pkg.sv
// Shared types for the synthetic accelerator: fold modes, ratio/wait widths.
package acc_dummy_pkg;

  localparam int unsigned RATIO_W = 16;
  localparam int unsigned WAIT_W  = 14;

  typedef enum logic [1:0] {
    FOLD_LAST = 2'd0,
    FOLD_XOR  = 2'd1,
    FOLD_SUM  = 2'd2,
    FOLD_INV  = 2'd3
  } fold_mode_t;

  typedef logic [RATIO_W-1:0] ratio_t;
  typedef logic [WAIT_W-1:0]  wait_t;

  // A ratio of zero means one beat.
  function automatic ratio_t eff_ratio(input ratio_t r);
    return (r == '0) ? ratio_t'(1) : r;
  endfunction

endpackage

// File: rtl/acc_dummy_gen_if.sv
// Consumer/producer valid-ready channels between the FIFO controller and the accelerator.
interface acc_dummy_gen_if #(
  parameter int unsigned DATA_W = 64
);
  logic              cons_valid;
  logic              cons_ready;
  logic [DATA_W-1:0] cons_data;
  logic              prod_valid;
  logic              prod_ready;
  logic [DATA_W-1:0] prod_data;

  // Accelerator side: sinks the consumer channel, sources the producer channel.
  modport slave (
    input  cons_valid, cons_data, prod_ready,
    output cons_ready, prod_valid, prod_data
  );

  // FIFO-controller side.
  modport master (
    output cons_valid, cons_data, prod_ready,
    input  cons_ready, prod_valid, prod_data
  );
endinterface

// File: rtl/acc_job_queue.sv
// Circular job queue; each entry carries a result, a private countdown and an output beat count.
module acc_job_queue
  import acc_dummy_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_JOBS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_result,
  input  wait_t                        push_wait,
  input  ratio_t                       push_deser,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(MAX_JOBS):0]    count,
  output logic                         head_eligible,
  output logic [DATA_W-1:0]            head_result,
  output ratio_t                       head_deser
);

  localparam int unsigned IDX_W = $clog2(MAX_JOBS);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [DATA_W-1:0] result_q [MAX_JOBS];
  wait_t             cnt_q    [MAX_JOBS];
  ratio_t            deser_q  [MAX_JOBS];

  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign wr_idx        = wr_ptr_q[IDX_W-1:0];
  assign rd_idx        = rd_ptr_q[IDX_W-1:0];
  assign empty         = (wr_ptr_q == rd_ptr_q);
  assign full          = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign count         = wr_ptr_q - rd_ptr_q;
  assign head_result   = result_q[rd_idx];
  assign head_deser    = deser_q[rd_idx];
  assign head_eligible = !empty && (cnt_q[rd_idx] == '0);

  // Pointer update; the wrap bit distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Entry write on push; every other entry counts down on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAX_JOBS); i++) begin
        result_q[i] <= '0;
        cnt_q[i]    <= '0;
        deser_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(MAX_JOBS); i++) begin
        if (push && (wr_idx == IDX_W'(i))) begin
          result_q[i] <= push_result;
          cnt_q[i]    <= push_wait;
          deser_q[i]  <= push_deser;
        end else if (cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - wait_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/acc_dummy_gen.sv
// Synthetic accelerator: folds ser-beat jobs, holds each result, then streams deser beats.
module acc_dummy_gen
  import acc_dummy_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_JOBS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  ratio_t                    cfg_ser_ratio,
  input  ratio_t                    cfg_deser_ratio,
  input  wait_t                     cfg_wait_cycles,
  input  fold_mode_t                cfg_mode,
  acc_dummy_gen_if.slave            bus,
  output logic [$clog2(MAX_JOBS):0] jobs_in_flight,
  output logic                      busy
);

  typedef enum logic {S_FIRST, S_ACCUM} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] acc_q;
  ratio_t            beat_cnt_q;
  ratio_t            ser_q;
  ratio_t            out_cnt_q;

  logic              q_full;
  logic              q_empty;
  logic              head_eligible;
  logic [DATA_W-1:0] head_result;
  ratio_t            head_deser;

  logic              cons_ready_c;
  logic              accept_c;
  logic [DATA_W-1:0] acc_base_c;
  logic [DATA_W-1:0] fold_c;
  ratio_t            ser_eff_c;
  logic              last_beat_c;
  logic              push_c;
  logic              fire_c;
  logic              pop_c;

  function automatic logic [DATA_W-1:0] fold(input fold_mode_t m,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    case (m)
      FOLD_LAST: return b;
      FOLD_XOR:  return a ^ b;
      FOLD_SUM:  return a + b;
      FOLD_INV:  return ~b;
      default:   return b;
    endcase
  endfunction

  // Intake datapath: ratio is sampled on the first beat, later beats use the latched copy.
  always_comb begin
    cons_ready_c = rst_n & ~q_full;
    accept_c     = bus.cons_valid & cons_ready_c;
    acc_base_c   = (state_q == S_FIRST) ? '0 : acc_q;
    ser_eff_c    = (state_q == S_FIRST) ? eff_ratio(cfg_ser_ratio) : ser_q;
    fold_c       = fold(cfg_mode, acc_base_c, bus.cons_data);
    last_beat_c  = ((beat_cnt_q + ratio_t'(1)) == ser_eff_c);
    push_c       = accept_c & last_beat_c;
  end

  // Intake fold FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FIRST;
      acc_q      <= '0;
      beat_cnt_q <= '0;
      ser_q      <= '0;
    end else if (accept_c) begin
      ser_q <= ser_eff_c;
      if (last_beat_c) begin
        state_q    <= S_FIRST;
        acc_q      <= '0;
        beat_cnt_q <= '0;
      end else begin
        state_q    <= S_ACCUM;
        acc_q      <= fold_c;
        beat_cnt_q <= beat_cnt_q + ratio_t'(1);
      end
    end
  end

  // Emit side: head entry streams result+i, popping on its final beat.
  always_comb begin
    fire_c = head_eligible & bus.prod_ready;
    pop_c  = fire_c && (out_cnt_q == (head_deser - ratio_t'(1)));
  end

  // Output beat counter for the head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
    end else if (fire_c) begin
      out_cnt_q <= pop_c ? '0 : (out_cnt_q + ratio_t'(1));
    end
  end

  acc_job_queue #(
    .DATA_W   (DATA_W),
    .MAX_JOBS (MAX_JOBS)
  ) u_queue (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (push_c),
    .push_result   (fold_c),
    .push_wait     (cfg_wait_cycles),
    .push_deser    (eff_ratio(cfg_deser_ratio)),
    .pop           (pop_c),
    .full          (q_full),
    .empty         (q_empty),
    .count         (jobs_in_flight),
    .head_eligible (head_eligible),
    .head_result   (head_result),
    .head_deser    (head_deser)
  );

  // Channel adapters; data is forced to zero whenever no beat is offered.
  assign bus.cons_ready = cons_ready_c;
  assign bus.prod_valid = head_eligible;
  assign bus.prod_data  = head_eligible ? (head_result + DATA_W'(out_cnt_q)) : '0;
  assign busy           = (state_q == S_ACCUM) | ~q_empty;

endmodule

// File: tb/tb_acc_dummy_gen.sv
// Bench for acc_dummy_gen: vector table plus directed sequences, scoreboard on the producer side.
module tb_acc_dummy_gen;
  import acc_dummy_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  ratio_t     cfg_ser_ratio;
  ratio_t     cfg_deser_ratio;
  wait_t      cfg_wait_cycles;
  fold_mode_t cfg_mode;
  logic [2:0] jobs_in_flight;
  logic       busy;

  acc_dummy_gen_if #(.DATA_W(64)) ifc ();

  acc_dummy_gen #(.DATA_W(64), .MAX_JOBS(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_ser_ratio   (cfg_ser_ratio),
    .cfg_deser_ratio (cfg_deser_ratio),
    .cfg_wait_cycles (cfg_wait_cycles),
    .cfg_mode        (cfg_mode),
    .bus             (ifc.slave),
    .jobs_in_flight  (jobs_in_flight),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int last_acc_cyc = 0;
  logic [63:0] exp_q[$];

  typedef struct packed {
    logic [15:0]      ser;
    logic [15:0]      deser;
    logic [13:0]      wt;
    fold_mode_t       mode;
    int               nb;
    logic [3:0][63:0] beats;
    logic [63:0]      res;
    int               ndeser;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] ser, input logic [15:0] deser, input logic [13:0] wt,
                              input fold_mode_t mode, input int nb,
                              input logic [63:0] b0, input logic [63:0] b1,
                              input logic [63:0] b2, input logic [63:0] b3,
                              input logic [63:0] res, input int ndeser);
    vec_t v;
    v.ser = ser; v.deser = deser; v.wt = wt; v.mode = mode; v.nb = nb;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3;
    v.res = res; v.ndeser = ndeser;
    return v;
  endfunction

  // Producer-side monitor: scoreboard compare, stall stability, zero data when idle.
  logic        stalled = 1'b0;
  logic [63:0] stall_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else if (!ifc.prod_valid) begin
      chk("idle_data_zero", ifc.prod_data, 64'h0);
      stalled = 1'b0;
    end else begin
      if (stalled) chk("stall_stable", ifc.prod_data, stall_data);
      if (ifc.prod_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got 0x%h expected none", ifc.prod_data);
        end else begin
          chk("out_data", ifc.prod_data, exp_q.pop_front());
        end
        stalled = 1'b0;
      end else begin
        stalled    = 1'b1;
        stall_data = ifc.prod_data;
      end
    end
  end

  task automatic send_beat(input logic [63:0] d);
    bit done = 1'b0;
    ifc.cons_valid = 1'b1;
    ifc.cons_data  = d;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (ifc.cons_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept of 0x%h", d);
    end
    #1;
    ifc.cons_valid = 1'b0;
    ifc.cons_data  = '0;
    last_acc_cyc   = cyc;
  endtask

  task automatic wait_valid(output int v);
    bit seen = 1'b0;
    v = -1;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (ifc.prod_valid) begin
        seen = 1'b1;
        v = cyc;
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL valid_timeout: got prod_valid=0 expected 1");
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v;
    int a;

    vecs[0] = mk(16'd4, 16'd2, 14'd3, FOLD_XOR,  4, 64'h1, 64'h2, 64'h4, 64'h8, 64'hF, 2);
    vecs[1] = mk(16'd0, 16'd0, 14'd0, FOLD_LAST, 1, 64'hAB, 64'h0, 64'h0, 64'h0, 64'hAB, 1);
    vecs[2] = mk(16'd3, 16'd1, 14'd0, FOLD_SUM,  3, 64'h5, 64'h6, 64'h7, 64'h0, 64'h12, 1);
    vecs[3] = mk(16'd2, 16'd2, 14'd1, FOLD_INV,  2, 64'h0, 64'hFF, 64'h0, 64'h0,
                 64'hFFFF_FFFF_FFFF_FF00, 2);
    vecs[4] = mk(16'd2, 16'd1, 14'd2, FOLD_LAST, 2, 64'h1234, 64'h5678, 64'h0, 64'h0, 64'h5678, 1);
    vecs[5] = mk(16'd1, 16'd3, 14'd0, FOLD_XOR,  1, 64'hDEAD, 64'h0, 64'h0, 64'h0, 64'hDEAD, 3);

    rst_n = 1'b0;
    ifc.cons_valid = 1'b0;
    ifc.cons_data  = '0;
    ifc.prod_ready = 1'b0;
    cfg_ser_ratio = '0; cfg_deser_ratio = '0; cfg_wait_cycles = '0; cfg_mode = FOLD_LAST;
    #3;
    chk("rst_cons_ready", 64'(ifc.cons_ready), 64'h0);
    chk("rst_prod_valid", 64'(ifc.prod_valid), 64'h0);
    chk("rst_prod_data",  ifc.prod_data, 64'h0);
    chk("rst_busy",       64'(busy), 64'h0);
    chk("rst_jobs",       64'(jobs_in_flight), 64'h0);
    #19;
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 64'(ifc.cons_ready), 64'h1);
    @(posedge clk); #1;

    // Table: one job at a time, prod_ready held high, first-valid latency equals the wait.
    ifc.prod_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      cfg_ser_ratio   = vecs[t].ser;
      cfg_deser_ratio = vecs[t].deser;
      cfg_wait_cycles = vecs[t].wt;
      cfg_mode        = vecs[t].mode;
      for (int i = 0; i < vecs[t].ndeser; i++) exp_q.push_back(vecs[t].res + 64'(i));
      for (int b = 0; b < vecs[t].nb; b++) send_beat(vecs[t].beats[b]);
      wait_valid(v);
      chk($sformatf("latency_vec%0d", t), 64'(v - last_acc_cyc), 64'(vecs[t].wt));
      drain();
      chk($sformatf("jobs_idle_vec%0d", t), 64'(jobs_in_flight), 64'h0);
      chk($sformatf("busy_idle_vec%0d", t), 64'(busy), 64'h0);
    end

    // Full queue: four jobs held, no bypass on the pop cycle, ready returns next cycle.
    cfg_ser_ratio = 16'd1; cfg_deser_ratio = 16'd1; cfg_wait_cycles = 14'd10; cfg_mode = FOLD_LAST;
    ifc.prod_ready = 1'b0;
    for (int k = 1; k <= 6; k++) exp_q.push_back(64'h100 + 64'(k));
    for (int k = 1; k <= 4; k++) send_beat(64'h100 + 64'(k));
    @(negedge clk);
    chk("full_cons_ready", 64'(ifc.cons_ready), 64'h0);
    chk("full_jobs", 64'(jobs_in_flight), 64'h4);
    chk("full_busy", 64'(busy), 64'h1);
    @(posedge clk); #1;
    ifc.prod_ready = 1'b1;
    wait_valid(v);
    chk("no_bypass_on_pop", 64'(ifc.cons_ready), 64'h0);
    @(negedge clk);
    chk("ready_after_pop", 64'(ifc.cons_ready), 64'h1);
    @(posedge clk); #1;
    send_beat(64'h105);
    send_beat(64'h106);
    drain();

    // Independent countdowns: a short-wait job stays behind a long-wait head.
    cfg_wait_cycles = 14'd20;
    exp_q.push_back(64'hA);
    exp_q.push_back(64'hB);
    send_beat(64'hA);
    a = last_acc_cyc;
    cfg_wait_cycles = 14'd0;
    @(posedge clk); #1;
    send_beat(64'hB);
    wait_valid(v);
    chk("head_wait_20", 64'(v - a), 64'd20);
    @(negedge clk);
    chk("second_immediate_valid", 64'(ifc.prod_valid), 64'h1);
    drain();

    // Backpressure and result+i wrap with random prod_ready.
    cfg_mode = FOLD_SUM; cfg_ser_ratio = 16'd2; cfg_deser_ratio = 16'd3; cfg_wait_cycles = 14'd0;
    ifc.prod_ready = 1'b0;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    exp_q.push_back(64'h0);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
      ifc.prod_ready = 1'($urandom_range(0, 1));
    end
    ifc.prod_ready = 1'b1;
    drain();

    // Reset with two jobs queued and a partial job in the fold.
    ifc.prod_ready = 1'b0;
    cfg_mode = FOLD_XOR; cfg_ser_ratio = 16'd1; cfg_deser_ratio = 16'd1; cfg_wait_cycles = 14'd0;
    send_beat(64'h11);
    send_beat(64'h22);
    cfg_ser_ratio = 16'd4;
    send_beat(64'h33);
    send_beat(64'h44);
    @(negedge clk);
    chk("pre_rst_jobs", 64'(jobs_in_flight), 64'h2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_cons_ready", 64'(ifc.cons_ready), 64'h0);
    chk("midrst_prod_valid", 64'(ifc.prod_valid), 64'h0);
    chk("midrst_prod_data",  ifc.prod_data, 64'h0);
    chk("midrst_busy",       64'(busy), 64'h0);
    chk("midrst_jobs",       64'(jobs_in_flight), 64'h0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    chk("ready_after_midrst", 64'(ifc.cons_ready), 64'h1);
    @(posedge clk); #1;
    ifc.prod_ready = 1'b1;
    cfg_ser_ratio = 16'd2;
    exp_q.push_back(64'h6);
    send_beat(64'h3);
    send_beat(64'h5);
    drain();
    chk("final_jobs", 64'(jobs_in_flight), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
